// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a write-port FIFO.
// Queued words are serialised LSB-first as start / data / [parity] / stop bits,
// with no idle gap between frames while the FIFO has data.
//
// Ports:
//   clk, reset   - system clock, asynchronous active-high reset
//   wr_en        - push request; dropped (wr_overflow pulse) when fifo_full
//   wr_data      - DATA_BITS word to push
//   fifo_full    - FIFO holds FIFO_DEPTH entries
//   fifo_level   - FIFO occupancy, 0..FIFO_DEPTH
//   wr_overflow  - one-cycle pulse after a dropped push
//   tx_line      - serial output, idles high
//   tx_busy      - high while a frame is on the line
//   tx_done      - one-cycle pulse in the first cycle after the last stop bit
//
// CLK_FREQ/BAUD_RATE must be >= 2; DATA_BITS 5..9; PARITY 0 none, 1 odd, 2 even;
// STOP_BITS 1 or 2; FIFO_DEPTH a power of two >= 2.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [DATA_BITS-1:0]        wr_data,
    output logic                        fifo_full,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        wr_overflow,
    output logic                        tx_line,
    output logic                        tx_busy,
    output logic                        tx_done
);
    localparam int              CPB      = CLK_FREQ / BAUD_RATE;
    localparam int              AW       = $clog2(FIFO_DEPTH);
    localparam logic [15:0]     CPB_M1   = 16'(CPB - 1);
    localparam logic [3:0]      DB_M1    = 4'(DATA_BITS - 1);
    localparam logic [3:0]      SB_M1    = 4'(STOP_BITS - 1);
    localparam logic [AW:0]     LVL_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]     LVL_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);

    // ---------------- FIFO ----------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          count;
    logic                 push, pop, empty;
    logic [DATA_BITS-1:0] head;

    assign fifo_full  = (count == LVL_FULL);
    assign fifo_level = count;
    assign empty      = (count == '0);
    // Acceptance looks only at the registered level, so a same-edge pop
    // never frees a slot for this push.
    assign push       = wr_en & ~fifo_full;
    assign head       = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            wr_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + LVL_ONE;
                2'b01:   count <= count - LVL_ONE;
                default: count <= count;
            endcase
            wr_overflow <= wr_en & fifo_full;
        end
    end

    // ---------------- transmitter FSM ----------------
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    typedef struct packed {
        state_t               st;
        logic [15:0]          baud;  // cycle within the current line bit
        logic [3:0]           bits;  // data bit / stop bit index
        logic [DATA_BITS-1:0] sh;    // remaining data bits, next one at [0]
        logic                 par;   // parity bit captured at load time
        logic                 line;
        logic                 busy;
        logic                 done;
    } tx_t;

    localparam tx_t TX_RST = '{st: IDLE, baud: '0, bits: '0, sh: '0,
                               par: 1'b0, line: 1'b1, busy: 1'b0, done: 1'b0};

    tx_t  r, n;
    logic baud_end, load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r <= TX_RST;
        else       r <= n;
    end

    always_comb begin
        n        = r;
        n.done   = 1'b0;
        load     = 1'b0;
        baud_end = (r.baud == CPB_M1);
        if (r.st != IDLE) n.baud = baud_end ? 16'd0 : r.baud + 16'd1;

        case (r.st)
            IDLE: load = ~empty;
            START: if (baud_end) begin
                n.st   = DATA;
                n.bits = 4'd0;
                n.line = r.sh[0];
                n.sh   = r.sh >> 1;
            end
            DATA: if (baud_end) begin
                if (r.bits == DB_M1) begin
                    n.bits = 4'd0;
                    if (PARITY != 0) begin
                        n.st   = PAR;
                        n.line = r.par;
                    end else begin
                        n.st   = STOP;
                        n.line = 1'b1;
                    end
                end else begin
                    n.bits = r.bits + 4'd1;
                    n.line = r.sh[0];
                    n.sh   = r.sh >> 1;
                end
            end
            PAR: if (baud_end) begin
                n.st   = STOP;
                n.bits = 4'd0;
                n.line = 1'b1;
            end
            STOP: if (baud_end) begin
                if (r.bits == SB_M1) begin
                    n.done = 1'b1;
                    // Chain straight into the next start bit when data is queued.
                    if (!empty) begin
                        load = 1'b1;
                    end else begin
                        n.st   = IDLE;
                        n.line = 1'b1;
                        n.busy = 1'b0;
                    end
                end else begin
                    n.bits = r.bits + 4'd1;
                end
            end
            default: n.st = IDLE;
        endcase

        // Pop the head word and start a frame; parity is taken from the whole word.
        if (load) begin
            n.st   = START;
            n.baud = 16'd0;
            n.bits = 4'd0;
            n.sh   = head;
            n.par  = (PARITY == 1) ? ~(^head) : (^head);
            n.line = 1'b0;
            n.busy = 1'b1;
        end
    end

    assign pop     = load;
    assign tx_line = r.line;
    assign tx_busy = r.busy;
    assign tx_done = r.done;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo. Four instances cover 8N1, 7O2, 7E1 and
// 9N1 frame formats. A spec-level model (word queue + cycle count into the
// frame) is checked against every instance on each falling edge; hand tables
// and sequences check exact frames, latency, chaining, overflow and reset.
module tb_uart_tx_fifo;
    localparam int NI    = 4;
    localparam int DEPTH = 4;
    localparam int DB  [NI] = '{8, 7, 7, 9};
    localparam int PARM[NI] = '{0, 1, 2, 0};
    localparam int SB  [NI] = '{1, 2, 1, 1};
    localparam int CPB [NI] = '{10, 4, 4, 3};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en  [NI];
    logic [8:0] wr_data[NI];
    logic       full[NI], ovf[NI], line[NI], busy[NI], done[NI];
    logic [2:0] lvl [NI];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_FREQ(100), .BAUD_RATE(10), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u0 (
        .clk(clk), .reset(reset), .wr_en(wr_en[0]), .wr_data(wr_data[0][7:0]),
        .fifo_full(full[0]), .fifo_level(lvl[0]), .wr_overflow(ovf[0]),
        .tx_line(line[0]), .tx_busy(busy[0]), .tx_done(done[0]));
    uart_tx_fifo #(.CLK_FREQ(40), .BAUD_RATE(10), .DATA_BITS(7), .PARITY(1),
                   .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u1 (
        .clk(clk), .reset(reset), .wr_en(wr_en[1]), .wr_data(wr_data[1][6:0]),
        .fifo_full(full[1]), .fifo_level(lvl[1]), .wr_overflow(ovf[1]),
        .tx_line(line[1]), .tx_busy(busy[1]), .tx_done(done[1]));
    uart_tx_fifo #(.CLK_FREQ(40), .BAUD_RATE(10), .DATA_BITS(7), .PARITY(2),
                   .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u2 (
        .clk(clk), .reset(reset), .wr_en(wr_en[2]), .wr_data(wr_data[2][6:0]),
        .fifo_full(full[2]), .fifo_level(lvl[2]), .wr_overflow(ovf[2]),
        .tx_line(line[2]), .tx_busy(busy[2]), .tx_done(done[2]));
    uart_tx_fifo #(.CLK_FREQ(30), .BAUD_RATE(10), .DATA_BITS(9), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u3 (
        .clk(clk), .reset(reset), .wr_en(wr_en[3]), .wr_data(wr_data[3]),
        .fifo_full(full[3]), .fifo_level(lvl[3]), .wr_overflow(ovf[3]),
        .tx_line(line[3]), .tx_busy(busy[3]), .tx_done(done[3]));

    task automatic chk(input string nm, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %0h expected %0h at %0t", nm, idx, act, exp, $time);
        end
    endtask

    // Line bits of a frame, bit k = k-th bit on the wire; unused upper bits are 1.
    function automatic logic [15:0] mk_frame(input int i, input logic [8:0] w);
        logic [15:0] f;
        int ones;
        f = '1;
        f[0] = 1'b0;
        ones = 0;
        for (int b = 0; b < DB[i]; b++) begin
            f[1+b] = w[b];
            ones += int'(w[b]);
        end
        if (PARM[i] == 1) f[1+DB[i]] = (ones % 2 == 0);
        else if (PARM[i] == 2) f[1+DB[i]] = (ones % 2 == 1);
        return f;
    endfunction

    function automatic int flen(input int i);
        return 1 + DB[i] + ((PARM[i] != 0) ? 1 : 0) + SB[i];
    endfunction

    // ---------------- reference model ----------------
    logic [8:0]  q[NI][$];
    logic        m_act[NI], m_done[NI], m_ovf[NI];
    int          m_cnt[NI];
    logic [15:0] m_cur[NI];

    // On each falling edge: compare outputs with the model's post-edge state,
    // then advance the model across the coming rising edge using the (stable) inputs.
    always @(negedge clk) begin
        int L;
        logic exp_line;
        if (reset) begin
            for (int i = 0; i < NI; i++) begin
                q[i].delete();
                m_act[i] = 1'b0; m_done[i] = 1'b0; m_ovf[i] = 1'b0; m_cnt[i] = 0;
            end
        end
        for (int i = 0; i < NI; i++) begin
            exp_line = m_act[i] ? m_cur[i][m_cnt[i] / CPB[i]] : 1'b1;
            chk("mon_line",  i, 16'(line[i]), 16'(exp_line));
            chk("mon_busy",  i, 16'(busy[i]), 16'(m_act[i]));
            chk("mon_done",  i, 16'(done[i]), 16'(m_done[i]));
            chk("mon_ovf",   i, 16'(ovf[i]),  16'(m_ovf[i]));
            chk("mon_level", i, 16'(lvl[i]),  16'(q[i].size()));
            chk("mon_full",  i, 16'(full[i]), 16'(q[i].size() == DEPTH));
        end
        if (!reset) begin
            for (int i = 0; i < NI; i++) begin
                L = q[i].size();
                m_ovf[i]  = wr_en[i] && (L == DEPTH);
                m_done[i] = 1'b0;
                if (m_act[i] && m_cnt[i] == flen(i) * CPB[i] - 1) begin
                    m_done[i] = 1'b1;
                    m_act[i]  = 1'b0;
                end else if (m_act[i]) begin
                    m_cnt[i]++;
                end
                if (!m_act[i] && L > 0) begin
                    m_cur[i] = mk_frame(i, q[i].pop_front());
                    m_act[i] = 1'b1;
                    m_cnt[i] = 0;
                end
                if (wr_en[i] && L < DEPTH) q[i].push_back(wr_data[i]);
            end
        end
    end

    // ---------------- directed tests ----------------
    typedef struct {
        int          inst;
        logic [8:0]  word;
        logic [15:0] frame;
        int          nbits;
    } vec_t;
    vec_t tbl[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int i);
        int n = 0;
        while ((busy[i] || lvl[i] != 0) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) chk("idle_timeout", i, 16'(1), 16'(0));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int i, gaps, dones, cnt_busy, cnt_low;
        for (int k = 0; k < NI; k++) begin
            wr_en[k] = 1'b0;
            wr_data[k] = '0;
        end
        tbl[0] = '{0, 9'h055, 16'h02AA, 10};  // 8N1 0x55
        tbl[1] = '{0, 9'h000, 16'h0200, 10};  // 8N1 0x00
        tbl[2] = '{1, 9'h003, 16'h0706, 11};  // 7O2 0x03, parity 1
        tbl[3] = '{1, 9'h07F, 16'h06FE, 11};  // 7O2 0x7F, parity 0
        tbl[4] = '{2, 9'h003, 16'h0206, 10};  // 7E1 0x03, parity 0
        tbl[5] = '{2, 9'h07F, 16'h03FE, 10};  // 7E1 0x7F, parity 1
        tbl[6] = '{3, 9'h1FF, 16'h07FE, 11};  // 9N1 all ones
        tbl[7] = '{3, 9'h0A5, 16'h054A, 11};  // 9N1 0x0A5

        repeat (3) tick();
        for (int k = 0; k < NI; k++) begin
            chk("rst_line", k, 16'(line[k]), 16'(1));
            chk("rst_busy", k, 16'(busy[k]), 16'(0));
            chk("rst_done", k, 16'(done[k]), 16'(0));
            chk("rst_ovf",  k, 16'(ovf[k]),  16'(0));
            chk("rst_lvl",  k, 16'(lvl[k]),  16'(0));
            chk("rst_full", k, 16'(full[k]), 16'(0));
        end
        reset = 1'b0;
        tick();

        // Single frames: exact bit pattern, latency and tx_done timing.
        for (int r = 0; r < 8; r++) begin
            i = tbl[r].inst;
            wait_idle(i);
            wr_en[i] = 1'b1;
            wr_data[i] = tbl[r].word;
            tick();                               // just after push edge E
            wr_en[i] = 1'b0;
            chk("row_k0_line", r, 16'(line[i]), 16'(1));
            chk("row_k0_lvl",  r, 16'(lvl[i]),  16'(1));
            for (int k = 1; k <= tbl[r].nbits * CPB[i] + 1; k++) begin
                tick();
                if (k == 1) chk("row_start", r, 16'(line[i]), 16'(0));
                if (k <= tbl[r].nbits * CPB[i] && (k - 1) % CPB[i] == CPB[i] / 2)
                    chk("row_bit", r, 16'(line[i]), 16'(tbl[r].frame[(k - 1) / CPB[i]]));
                if (k == tbl[r].nbits * CPB[i]) chk("row_done_early", r, 16'(done[i]), 16'(0));
                if (k == tbl[r].nbits * CPB[i] + 1) begin
                    chk("row_done", r, 16'(done[i]), 16'(1));
                    chk("row_idle", r, 16'(busy[i]), 16'(0));
                end
            end
        end

        // Back-to-back frames with two stop bits (44-cycle frames on u1).
        wait_idle(1);
        wr_en[1] = 1'b1;
        wr_data[1] = 9'h021;
        tick();
        wr_data[1] = 9'h03C;
        gaps = 0;
        dones = 0;
        for (int k = 1; k <= 89; k++) begin
            tick();
            if (k == 1) wr_en[1] = 1'b0;
            if (k <= 88 && !busy[1]) gaps++;
            if (done[1]) dones++;
            if (k == 45) begin
                chk("b2b_done1",  1, 16'(done[1]), 16'(1));
                chk("b2b_start2", 1, 16'(line[1]), 16'(0));
            end
            if (k == 89) begin
                chk("b2b_done2", 1, 16'(done[1]), 16'(1));
                chk("b2b_idle",  1, 16'(busy[1]), 16'(0));
            end
        end
        chk("b2b_gaps",  1, 16'(gaps),  16'(0));
        chk("b2b_dones", 1, 16'(dones), 16'(2));

        // Overflow: keep u0 busy, fill 4 slots, 5th push is dropped.
        wait_idle(0);
        wr_en[0] = 1'b1;
        wr_data[0] = 9'h011;
        tick();
        wr_en[0] = 1'b0;
        tick();
        for (int p = 0; p < 5; p++) begin
            wr_en[0] = 1'b1;
            wr_data[0] = 9'(9'h060 + p);
            tick();
            if (p == 3) begin
                chk("ovf_lvl4",  0, 16'(lvl[0]),  16'(4));
                chk("ovf_full",  0, 16'(full[0]), 16'(1));
                chk("ovf_quiet", 0, 16'(ovf[0]),  16'(0));
            end
            if (p == 4) begin
                chk("ovf_pulse", 0, 16'(ovf[0]), 16'(1));
                chk("ovf_keep",  0, 16'(lvl[0]), 16'(4));
            end
        end
        wr_en[0] = 1'b0;
        tick();
        chk("ovf_one_cycle", 0, 16'(ovf[0]), 16'(0));
        wait_idle(0);

        // Reset during data bit 3 with two words queued.
        wr_en[0] = 1'b1;
        wr_data[0] = 9'h0F0;
        tick();
        wr_data[0] = 9'h00F;
        tick();
        wr_data[0] = 9'h033;
        tick();
        wr_en[0] = 1'b0;
        repeat (42) tick();                       // now k = 44
        chk("rmf_lvl_before", 0, 16'(lvl[0]), 16'(2));
        tick();                                   // k = 45, data bit 3 (0) on the line
        chk("rmf_line_before", 0, 16'(line[0]), 16'(0));
        reset = 1'b1;
        #1;
        chk("rmf_line", 0, 16'(line[0]), 16'(1));
        chk("rmf_busy", 0, 16'(busy[0]), 16'(0));
        chk("rmf_lvl",  0, 16'(lvl[0]),  16'(0));
        chk("rmf_full", 0, 16'(full[0]), 16'(0));
        tick();
        reset = 1'b0;
        cnt_busy = 0;
        cnt_low = 0;
        repeat (300) begin
            tick();
            if (busy[0]) cnt_busy++;
            if (!line[0]) cnt_low++;
        end
        chk("rmf_no_busy", 0, 16'(cnt_busy), 16'(0));
        chk("rmf_no_frame", 0, 16'(cnt_low), 16'(0));

        // Randomized traffic on all instances: sparse, heavy (overflowing), then trickle.
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NI; k++) begin
                wr_en[k] = ($urandom_range(0, 99) < ((c < 1000) ? 3 : (c < 2000) ? 40 : 1));
                wr_data[k] = 9'($urandom);
            end
            tick();
        end
        for (int k = 0; k < NI; k++) wr_en[k] = 1'b0;
        for (int k = 0; k < NI; k++) wait_idle(k);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an input FIFO, configurable frame format (data width, parity, stop bits), and back-to-back frame streaming. It is the next-generation TX path for the UART subsystem. Host logic pushes words through a simple write port. The block serialises them LSB-first on `tx_line` at a fixed baud rate with no idle gap between queued frames.

## Interface

Parameters:
- `CLK_FREQ`, 50000000, system clock frequency in Hz.
- `BAUD_RATE`, 9600, line rate in bits/s. `CPB = CLK_FREQ/BAUD_RATE` (integer division, must be ≥ 2).
- `DATA_BITS`, 8, data bits per frame; legal range 5–9.
- `PARITY`, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1, stop bits per frame; legal values 1 or 2.
- `FIFO_DEPTH`, 16, FIFO entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  reset: asynchronous, active-high.
- `wr_en`  in  1  push request.
- `wr_data`  in  `DATA_BITS`  word to push.
- `fifo_full`  out  1  FIFO holds `FIFO_DEPTH` entries.
- `fifo_level`  out  `$clog2(FIFO_DEPTH)+1`  current FIFO occupancy.
- `wr_overflow`  out  1  one-cycle pulse when a push is dropped.
- `tx_line`  out  1  serial output; idles high.
- `tx_busy`  out  1  high while a frame is on the line.
- `tx_done`  out  1  one-cycle pulse at the end of each frame.

## Operation

- Reset values: `tx_line=1`, `tx_busy=0`, `tx_done=0`, `wr_overflow=0`, `fifo_level=0`, `fifo_full=0`. The FSM enters IDLE and the FIFO is emptied.
- Push rule:
  - A push is accepted iff `wr_en=1` and `fifo_full=0` at the clock edge. A simultaneous pop does not free a slot for that same push.
  - If `wr_en=1` while `fifo_full=1`, the data is dropped and `wr_overflow` pulses high for one cycle.
- Frame format: start bit (0), then `DATA_BITS` data bits LSB first, then an optional parity bit, then `STOP_BITS` stop bits (1).
  - Odd parity: the parity bit makes the count of ones across data+parity odd.
  - Even parity: the parity bit makes that count even.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE → START when the FIFO is not empty. On that edge the FSM pops the head word into the shift register, drives `tx_line` to 0, sets `tx_busy` to 1, and clears the bit counter.
  - START → DATA after `CPB` cycles.
  - DATA → PAR (if `PARITY≠0`) or STOP, after `DATA_BITS×CPB` cycles.
  - PAR → STOP after `CPB` cycles.
  - STOP → IDLE after `STOP_BITS×CPB` cycles. On that edge `tx_done` pulses. If the FIFO is not empty on that same edge, the FSM pops and goes directly to START with no idle bit, and `tx_busy` stays high. Otherwise `tx_line` is 1 and `tx_busy` drops to 0.
- Parity is computed from the popped word when it is loaded, not bit-by-bit on the line.
- A 16-bit baud counter counts 0..`CPB`−1. Each line bit is held for exactly `CPB` cycles.
- Reset asserted mid-frame: `tx_line` goes to 1 immediately, the frame is abandoned, and queued data is discarded.

## Timing

- Latency: a push accepted at edge E into an empty FIFO with the FSM in IDLE gives `tx_line=0` from edge E+1.
- Frame length: `(1 + DATA_BITS + (PARITY?1:0) + STOP_BITS) × CPB` cycles, measured from the falling start edge to the `tx_done` edge.
- `tx_done` is high for exactly one cycle, coincident with the first cycle after the last stop bit.
- `fifo_level` updates on the edge of each push or pop. A simultaneous accepted push and pop leaves the level unchanged.
- `fifo_full` and `fifo_level` are registered, or derived combinationally from registered pointers; neither may depend combinationally on `wr_en`.

## Test plan

- **8N1 single byte:** `CPB=10`, push 0x55 into an idle block.
  - `tx_line=0` at E+1.
  - Then bits 1,0,1,0,1,0,1,0, each 10 cycles, then stop = 1.
  - `tx_done` pulses at E+1+100.
- **Parity:** `PARITY=1` (odd), `DATA_BITS=7`, push 0x03 → parity bit = 1. With `PARITY=2` (even), push 0x03 → parity bit = 0. Frame is 10 bits = 100 cycles.
- **Two stop bits, back-to-back:** `STOP_BITS=2`, push 0xA1, 0x3C on consecutive cycles.
  - The second start bit begins on the same edge as the first `tx_done`.
  - `tx_busy` is continuous for 2×110 cycles.
  - `tx_done` pulses twice.
- **Overflow:** `FIFO_DEPTH=4`, FSM held busy. The first 4 pushes are accepted (`fifo_level` reaches 4 and `fifo_full=1`); the 5th push gives a `wr_overflow` pulse.
  - Later output is exactly the first 4 words, in order.
- **Reset mid-frame:** assert `reset` during data bit 3 with 2 words queued.
  - `tx_line=1` and `tx_busy=0` immediately.
  - `fifo_level=0`; no further frames are sent.
- **9-bit data:** `DATA_BITS=9`, push 0x1FF → nine 1-bits, and the frame is `(11)×CPB` cycles.
